// File: rtl/softmax_pkg.sv
// Shared definitions for the softmax datapath.
// Holds the Q4.12 data format widths, the fixed-point constants used around the
// log2 / pow2 loop, and the state type of the log2-sum accumulator FSM.
package softmax_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned FRAC_W = 12;

    localparam logic [DATA_W-1:0] Q_ONE     = 16'h1000;
    // Most negative Q4.12 value; stands in for log2(0).
    localparam logic [DATA_W-1:0] LOG2_ZERO = 16'h8000;
    localparam logic [DATA_W-1:0] Q_MAX     = 16'h7FFF;

    typedef enum logic [1:0] {
        StIdle,
        StAcc,
        StLog,
        StDone
    } state_e;

endpackage

// File: rtl/log2_sum_acc_if.sv
// Handshake bundle of the log2-sum accumulator.
// Signals:
//   start/len               vector start request and its term count
//   in_valid/in_data/in_ready   exp-term stream (signed Q4.12)
//   out_valid/out_log2sum/out_ready  result handshake (signed Q4.12)
//   busy                    block is not idle
// Modports: slave = accumulator side, master = producer/consumer side.
interface log2_sum_acc_if #(
    parameter int unsigned LEN_W = 8
) ();

    logic                             start;
    logic [LEN_W-1:0]                 len;
    logic                             in_valid;
    logic [softmax_pkg::DATA_W-1:0]   in_data;
    logic                             in_ready;
    logic                             out_valid;
    logic [softmax_pkg::DATA_W-1:0]   out_log2sum;
    logic                             out_ready;
    logic                             busy;

    modport slave (
        input  start,
        input  len,
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_log2sum,
        output busy
    );

    modport master (
        output start,
        output len,
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_log2sum,
        input  busy
    );

endinterface

// File: rtl/log2_lin_approx.sv
// Combinational piecewise-linear log2 of an unsigned fixed-point value with
// FRAC_W fractional bits, producing a saturated signed Q4.12 result.
// log2(2^p * (1+f)) ~= p + f, where f is the bits below the leading one.
// Ports:
//   acc_i   unsigned input, IN_W bits, FRAC_W fractional bits
//   log2_o  signed Q4.12 log2 approximation (LOG2_ZERO for a zero input)
module log2_lin_approx
    import softmax_pkg::*;
#(
    parameter int unsigned IN_W = 24
) (
    input  logic [IN_W-1:0]   acc_i,
    output logic [DATA_W-1:0] log2_o
);

    localparam int unsigned PW     = $clog2(IN_W);
    localparam int          IntW   = DATA_W - FRAC_W;
    localparam int          MaxInt = (2 ** (IntW - 1)) - 1;
    localparam int          MinInt = -(2 ** (IntW - 1));

    logic [PW-1:0]      lead;
    logic [FRAC_W-1:0]  frac;
    logic signed [31:0] exp_s;

    always_comb begin
        lead = '0;
        // Highest set bit wins since later iterations overwrite earlier ones.
        for (int i = 0; i < int'(IN_W); i++) begin
            if (acc_i[i]) begin
                lead = PW'(i);
            end
        end

        // Append FRAC_W zeros so bits below a low leading one zero-fill.
        frac  = FRAC_W'({acc_i, {FRAC_W{1'b0}}} >> lead);
        exp_s = 32'(lead) - 32'(FRAC_W);

        if (acc_i == '0) begin
            log2_o = LOG2_ZERO;
        end else if (exp_s > MaxInt) begin
            log2_o = Q_MAX;
        end else if (exp_s < MinInt) begin
            log2_o = LOG2_ZERO;
        end else begin
            log2_o = {exp_s[IntW-1:0], frac};
        end
    end

endmodule

// File: rtl/log2_sum_acc.sv
// Log2-sum accumulator between the two softmax passes.
// Sums the clamped Q4.12 exp terms of one vector, then registers the linear
// log2 approximation of the sum as the stage-2 log2_sum operand.
// Ports:
//   clk     clock, rising edge
//   rst_n   asynchronous active-low reset
//   bus_io  handshake bundle (slave side): start/len, term stream, result, busy
module log2_sum_acc
    import softmax_pkg::*;
#(
    parameter int unsigned LEN_W = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    log2_sum_acc_if.slave bus_io
);

    // Wide enough for (2^LEN_W - 1) maximal terms, so no overflow handling.
    localparam int unsigned ACC_W = DATA_W + LEN_W;

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [DATA_W-1:0]  res_q, res_d;
    logic [DATA_W-1:0]  term;
    logic [DATA_W-1:0]  log2_val;

    log2_lin_approx #(
        .IN_W (ACC_W)
    ) u_log2 (
        .acc_i  (acc_q),
        .log2_o (log2_val)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        res_d   = res_q;
        // Exp terms are never meaningfully negative; clamp them to zero.
        term    = bus_io.in_data[DATA_W-1] ? '0 : bus_io.in_data;

        unique case (state_q)
            StIdle: begin
                if (bus_io.start && (bus_io.len != '0)) begin
                    state_d = StAcc;
                    acc_d   = '0;
                    cnt_d   = '0;
                    len_d   = bus_io.len;
                end
            end
            StAcc: begin
                if (bus_io.in_valid) begin
                    acc_d = acc_q + ACC_W'(term);
                    cnt_d = cnt_q + LEN_W'(1);
                    if (cnt_d == len_q) begin
                        state_d = StLog;
                    end
                end
            end
            StLog: begin
                res_d   = log2_val;
                state_d = StDone;
            end
            StDone: begin
                if (bus_io.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            acc_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            res_q   <= res_d;
        end
    end

    assign bus_io.in_ready    = (state_q == StAcc);
    assign bus_io.out_valid   = (state_q == StDone);
    assign bus_io.busy        = (state_q != StIdle);
    assign bus_io.out_log2sum = res_q;

endmodule

// File: doc/log2_sum_acc.md
# log2_sum_acc

Accumulates the Q4.12 exponential terms produced by the softmax reconfigurable unit in stage 1 over one input vector. After the last term it computes a piecewise-linear log2 of the sum and presents the Q4.12 result. That result is the `log2_sum` operand fed back to the reconfigurable unit in stage 2. The block sits directly downstream of the unit's pow2 output and closes the loop between the two softmax passes.

## Interface
- `DATA_W`, 16: width of input terms and result (Q4.12, signed)
- `FRAC_W`, 12: fractional bits
- `LEN_W`, 8: vector-length width; max vector length is 2^LEN_W − 1
- `clk`  in  1: single clock, rising edge
- `rst_n`  in  1: reset, asynchronous, active-low
- `start`  in  1: begin a vector; sampled only in IDLE
- `len`  in  LEN_W: number of terms in the vector, sampled with `start`
- `in_valid`  in  1: term available
- `in_data`  in  DATA_W: signed Q4.12 exp term (RU `out_1`)
- `in_ready`  out  1: block accepts a term
- `out_valid`  out  1: result valid
- `out_log2sum`  out  DATA_W: signed Q4.12 log2 of the accumulated sum
- `out_ready`  in  1: consumer takes the result
- `busy`  out  1: high in any state other than IDLE

## Operation
- States: IDLE, ACC, LOG, DONE.
- IDLE:
  - `start`=1 with `len`≠0 → ACC; accumulator `acc` cleared, count cleared, `len` latched.
  - `start` with `len`=0 is ignored.
- ACC:
  - `in_ready`=1.
  - Each handshake (`in_valid`&&`in_ready`) adds `in_data` to `acc`; negative terms are clamped to 0 before adding.
  - `acc` is unsigned, DATA_W+LEN_W bits wide, FRAC_W fractional bits, so it never overflows.
  - When the handshake brings count to the latched length → LOG.
- LOG (one cycle):
  - p = index of the leading one of `acc`.
  - Integer part = p − FRAC_W.
  - Fraction = the FRAC_W bits directly below the leading one. Zero-fill on the right when p < FRAC_W. This is log2(1+f) ≈ f.
  - Result = {integer, fraction} in Q4.12, registered; → DONE.
- Result saturation:
  - Integer part > 7 → 0x7FFF.
  - Integer part < −8 → 0x8000.
  - `acc`=0 → 0x8000, the log2(0) sentinel.
- DONE: `out_valid`=1, `out_log2sum` held stable; handshake with `out_ready` → IDLE.
- `start` outside IDLE is ignored. `in_valid` outside ACC is ignored, and `in_ready` is 0 there.
- Reset values: state IDLE, `acc`=0, count 0, `in_ready`=0, `out_valid`=0, `out_log2sum`=0, `busy`=0.
- Reset asserted mid-vector aborts immediately. Partial sums are discarded and no output is produced.

## Timing
- Start accepted at edge k → ACC from k; first term is accepted at the earliest edge k+1.
- One term is accepted per cycle at most; there are no bubbles while `in_valid` is held high.
- Last term accepted at edge m → LOG after m → `out_valid` high after edge m+1. Latency is two edges from the last term to the result.
- `out_ready` held high in DONE → IDLE after the next edge. A new `start` is sampled one cycle later at the earliest.
- `out_ready` low holds DONE and the result indefinitely.
- All outputs are registered or decoded from the registered state; there is no combinational path from inputs to outputs.

## Structure
- Shared package `softmax_pkg` holds:
  - `DATA_W` and `FRAC_W`.
  - `Q_ONE` (0x1000), `LOG2_ZERO` (0x8000), `Q_MAX` (0x7FFF).
  - The state enum type.
- Sub-module `log2_lin_approx` (combinational): leading-one detect, fraction extraction, saturation. It is reusable by any other log2 site in the datapath.
- The top level holds the FSM, the counter, the accumulator and the output register.

## Test plan
- `len`=4, four terms of 0x1000 → `out_log2sum`=0x2000 (2.0); `out_valid` 2 edges after the 4th handshake.
- `len`=3, three terms of 0x1000 (sum 3.0) → 0x1800 (1.5, linear approximation).
- `len`=1, term 0x0800 (0.5) → 0xF000 (−1.0).
- `len`=2, terms 0x0000 and 0xF000 (negative, clamped) → 0x8000 sentinel.
- `len`=255, all terms 0x7FFF → 0x7FFF (saturated).
- Reset during ACC after 2 of 4 terms; `out_ready` low for 5 cycles in DONE:
  - Reset → all outputs at reset values, `busy`=0.
  - Next vector `len`=4, terms 0x1000 → 0x2000, `in_ready`=0 and result stable while held.
